// File: rtl/traffic_countdown_display.sv
// Scans two 2-digit BCD countdowns onto a 4-digit multiplexed 7-segment display and flags bad BCD.
// Optional blinking of low countdowns is built only when TRAFFIC_DISP_BLINK_EN is defined.
module traffic_countdown_display #(
    parameter int         SCAN_DIV     = 4,
    parameter int         BLINK_FRAMES = 8,
    parameter logic [7:0] BLINK_THRESH = 8'h05
) (
    input  logic       CLK,
    input  logic       R,
    input  logic       A_Light,
    input  logic       B_Light,
    input  logic [7:0] A_Count,
    input  logic [7:0] B_Count,
    output logic [6:0] Seg,
    output logic       Dp,
    output logic [3:0] DigitEn,
    output logic       Err
);

    // state        | meaning
    // SLOT_A_TENS  | A tens digit being scanned
    // SLOT_A_UNITS | A units digit being scanned
    // SLOT_B_TENS  | B tens digit being scanned
    // SLOT_B_UNITS | B units digit being scanned; its last cycle captures the next frame
    typedef enum logic [1:0] {
        SLOT_A_TENS  = 2'd0,
        SLOT_A_UNITS = 2'd1,
        SLOT_B_TENS  = 2'd2,
        SLOT_B_UNITS = 2'd3
    } slot_t;

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    if (SCAN_DIV < 1) begin : g_bad_scan_div
        $error("SCAN_DIV must be at least 1");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
        $error("BLINK_FRAMES must be at least 1");
    end
    if (BLINK_THRESH[7:4] > 4'd9 || BLINK_THRESH[3:0] > 4'd9) begin : g_bad_blink_thresh
        $error("BLINK_THRESH must be valid BCD");
    end

    logic [DIV_W-1:0] div;
    slot_t            idx;
    logic [7:0]       sh_a_count;
    logic [7:0]       sh_b_count;
    logic             sh_a_light;
    logic             sh_b_light;

    logic [3:0] nibble;
    logic       is_tens;
    logic       bad_digit;
    logic [6:0] seg_next;
    logic       dp_next;
    logic [3:0] en_next;
    logic       slot_end;
    logic       frame_wrap;
    logic       suppress;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    seg_decode = 7'b0111111;
            4'd1:    seg_decode = 7'b0000110;
            4'd2:    seg_decode = 7'b1011011;
            4'd3:    seg_decode = 7'b1001111;
            4'd4:    seg_decode = 7'b1100110;
            4'd5:    seg_decode = 7'b1101101;
            4'd6:    seg_decode = 7'b1111101;
            4'd7:    seg_decode = 7'b0000111;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1101111;
            default: seg_decode = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        nibble = 4'd0;
        case (idx)
            SLOT_A_TENS:  nibble = sh_a_count[7:4];
            SLOT_A_UNITS: nibble = sh_a_count[3:0];
            SLOT_B_TENS:  nibble = sh_b_count[7:4];
            default:      nibble = sh_b_count[3:0];
        endcase
    end

    assign slot_end   = (div == DIV_LAST);
    assign frame_wrap = slot_end && (idx == SLOT_B_UNITS);
    assign is_tens    = (idx == SLOT_A_TENS) || (idx == SLOT_B_TENS);
    assign bad_digit  = (nibble > 4'd9);
    // Only tens digits get leading-zero blanking; a lone 0 must still read as 0.
    assign seg_next   = bad_digit                   ? 7'b1000000 :
                        (is_tens && nibble == 4'd0) ? 7'b0000000 :
                                                      seg_decode(nibble);
    assign dp_next    = ((idx == SLOT_A_UNITS) && sh_a_light) ||
                        ((idx == SLOT_B_UNITS) && sh_b_light);
    assign en_next    = 4'b0001 << idx;

`ifdef TRAFFIC_DISP_BLINK_EN
    localparam int               FRAME_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    logic [FRAME_W-1:0] frame_cnt;
    logic               blink_phase;
    logic               a_low;
    logic               b_low;

    function automatic logic bcd_low(input logic [7:0] c);
        bcd_low = (c[7:4] <= 4'd9) && (c[3:0] <= 4'd9) && (c <= BLINK_THRESH);
    endfunction

    assign a_low    = bcd_low(sh_a_count);
    assign b_low    = bcd_low(sh_b_count);
    assign suppress = !blink_phase &&
                      (((idx == SLOT_A_TENS) || (idx == SLOT_A_UNITS)) ? a_low : b_low);

    always_ff @(posedge CLK) begin
        if (R) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (frame_wrap) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`else
    assign suppress = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (R) begin
            div        <= '0;
            idx        <= SLOT_A_TENS;
            Err        <= 1'b0;
            Seg        <= 7'd0;
            Dp         <= 1'b0;
            DigitEn    <= 4'd0;
            sh_a_count <= A_Count;
            sh_b_count <= B_Count;
            sh_a_light <= A_Light;
            sh_b_light <= B_Light;
        end else begin
            if (slot_end) begin
                div <= '0;
                idx <= slot_t'(idx + 2'd1);
            end else begin
                div <= div + 1'b1;
            end
            if (frame_wrap) begin
                sh_a_count <= A_Count;
                sh_b_count <= B_Count;
                sh_a_light <= A_Light;
                sh_b_light <= B_Light;
            end
            Err <= Err | bad_digit;
            if (suppress) begin
                Seg     <= 7'd0;
                Dp      <= 1'b0;
                DigitEn <= 4'd0;
            end else begin
                Seg     <= seg_next;
                Dp      <= dp_next;
                DigitEn <= en_next;
            end
        end
    end

endmodule
